// File: rtl/izhikevich_integrator.sv
// Izhikevich state-update stage: holds v/w, Euler-integrates with dv from calc_dv, applies spike reset.
// Sign-magnitude fixed point throughout. Define IZH_SPIKE_COUNT_EN to add the spike_count output.
module izhikevich_integrator #(
    parameter int           N      = 32,
    parameter int           Q      = 16,
    parameter logic [N-1:0] A      = 32'h0000051E,
    parameter logic [N-1:0] B      = 32'h00003333,
    parameter logic [N-1:0] C      = 32'h80410000,
    parameter logic [N-1:0] D      = 32'h00080000,
    parameter logic [N-1:0] DT     = 32'h00010000,
    parameter logic [N-1:0] V_TH   = 32'h001E0000,
    parameter logic [N-1:0] V_INIT = 32'h80410000,
    parameter logic [N-1:0] W_INIT = 32'h800D0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dv_in,
    output logic [N-1:0] v_state,
    output logic [N-1:0] w_state,
    output logic         busy,
    output logic         done,
    output logic         spike
`ifdef IZH_SPIKE_COUNT_EN
    ,
    output logic [15:0]  spike_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_INTEGRATE,
        S_SPIKE,
        S_DONE
    } state_t;

    function automatic logic [N-1:0] smNorm(input logic [N-1:0] x);
        smNorm = (x[N-2:0] == '0) ? '0 : x;
    endfunction

    // Magnitude product is shifted back by Q and truncated to N-1 bits; high bits are dropped.
    function automatic logic [N-1:0] smMul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-3:0] prod;
        logic [N-2:0]   mag;
        prod   = {{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, y[N-2:0]};
        mag    = (N-1)'(prod >> Q);
        smMul  = smNorm({x[N-1] ^ y[N-1], mag});
    endfunction

    function automatic logic [N-1:0] smAdd(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-2:0] mx;
        logic [N-2:0] my;
        logic [N-1:0] r;
        mx = x[N-2:0];
        my = y[N-2:0];
        if (x[N-1] == y[N-1]) begin
            r = {x[N-1], mx + my};
        end else if (mx >= my) begin
            r = {x[N-1], mx - my};
        end else begin
            r = {y[N-1], my - mx};
        end
        smAdd = smNorm(r);
    endfunction

    // Mapping to two's complement makes +0 and -0 compare equal.
    function automatic logic signed [N:0] smToInt(input logic [N-1:0] x);
        logic signed [N:0] m;
        m       = {2'b00, x[N-2:0]};
        smToInt = x[N-1] ? -m : m;
    endfunction

    state_t       r_state;
    logic [N-1:0] r_v;
    logic [N-1:0] r_w;
    logic [N-1:0] r_dv;
    logic [N-1:0] r_dw;
    logic [N-1:0] r_vTmp;
    logic [N-1:0] r_wTmp;
    logic         r_busy;
    logic         r_done;
    logic         r_spike;

    logic [N-1:0] w_bv;
    logic [N-1:0] w_dwSum;
    logic [N-1:0] w_dw;
    logic [N-1:0] w_vTmp;
    logic [N-1:0] w_wTmp;
    logic [N-1:0] w_wSpike;
    logic         w_fire;

    assign w_bv     = smMul(B, r_v);
    assign w_dwSum  = smAdd(w_bv, {~r_w[N-1], r_w[N-2:0]});
    assign w_dw     = smMul(A, w_dwSum);
    assign w_vTmp   = smAdd(r_v, smMul(DT, r_dv));
    assign w_wTmp   = smAdd(r_w, smMul(DT, r_dw));
    assign w_wSpike = smAdd(r_wTmp, D);
    assign w_fire   = (smToInt(r_vTmp) >= smToInt(V_TH));

    // Step sequencer; v/w only change on the SPIKE->DONE edge so they are valid in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_v     <= V_INIT;
            r_w     <= W_INIT;
            r_dv    <= '0;
            r_dw    <= '0;
            r_vTmp  <= '0;
            r_wTmp  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_spike <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_spike <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SAMPLE;
                        r_busy  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_dv    <= smNorm(dv_in);
                    r_dw    <= w_dw;
                    r_state <= S_INTEGRATE;
                end
                S_INTEGRATE: begin
                    r_vTmp  <= w_vTmp;
                    r_wTmp  <= w_wTmp;
                    r_state <= S_SPIKE;
                end
                S_SPIKE: begin
                    if (w_fire) begin
                        r_v <= smNorm(C);
                        r_w <= w_wSpike;
                    end else begin
                        r_v <= r_vTmp;
                        r_w <= r_wTmp;
                    end
                    r_done  <= 1'b1;
                    r_spike <= w_fire;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IZH_SPIKE_COUNT_EN
    logic [15:0] r_spikeCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spikeCount <= '0;
        end else if (r_state == S_SPIKE && w_fire) begin
            r_spikeCount <= r_spikeCount + 16'd1;
        end
    end

    assign spike_count = r_spikeCount;
`endif

    assign v_state = r_v;
    assign w_state = r_w;
    assign busy    = r_busy;
    assign done    = r_done;
    assign spike   = r_spike;

endmodule

// File: tb/tb_izhikevich_integrator.sv
// Testbench for izhikevich_integrator: directed steps plus random dv checked against an integer-valued model.
// Spike counter checks are compiled in when IZH_SPIKE_COUNT_EN is defined.
module tb_izhikevich_integrator;

    localparam longint TWO31  = 64'sd1 << 31;
    localparam longint A_V    = 1310;
    localparam longint B_V    = 13107;
    localparam longint C_V    = -(64'sd65 << 16);
    localparam longint D_V    = 64'sd8 << 16;
    localparam longint DT_V   = 64'sd1 << 16;
    localparam longint VTH_V  = 64'sd30 << 16;
    localparam longint VINI_V = -(64'sd65 << 16);
    localparam longint WINI_V = -(64'sd13 << 16);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dv_in = '0;
    logic [31:0] v_state;
    logic [31:0] w_state;
    logic        busy;
    logic        done;
    logic        spike;
`ifdef IZH_SPIKE_COUNT_EN
    logic [15:0] spike_count;
`endif

    int          checks = 0;
    int          errors = 0;
    longint      mV;
    longint      mW;
    logic [15:0] mCount;

    izhikevich_integrator dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dv_in   (dv_in),
        .v_state (v_state),
        .w_state (w_state),
        .busy    (busy),
        .done    (done),
        .spike   (spike)
`ifdef IZH_SPIKE_COUNT_EN
        ,
        .spike_count (spike_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Values are held as plain signed integers in units of 2^-16.
    function automatic longint toVal(input logic [31:0] x);
        longint m;
        m = longint'({33'd0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] fromVal(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {(v < 0), m[30:0]};
    endfunction

    function automatic longint mulM(input longint x, input longint y);
        longint mag;
        mag = ((((x < 0) ? -x : x) * ((y < 0) ? -y : y)) >> 16) % TWO31;
        return ((x < 0) != (y < 0)) ? -mag : mag;
    endfunction

    function automatic longint addM(input longint x, input longint y);
        longint s;
        s = x + y;
        if (x >= 0 && y >= 0 && s >= TWO31) s = s % TWO31;
        else if (x < 0 && y < 0 && s <= -TWO31) s = -((-s) % TWO31);
        return s;
    endfunction

    task automatic modelReset();
        mV     = VINI_V;
        mW     = WINI_V;
        mCount = '0;
    endtask

    task automatic modelStep(input longint dv, output bit fire);
        longint dw;
        longint vt;
        longint wt;
        dw = mulM(A_V, addM(mulM(B_V, mV), -mW));
        vt = addM(mV, mulM(DT_V, dv));
        wt = addM(mW, mulM(DT_V, dw));
        fire = (vt >= VTH_V);
        if (fire) begin
            mV     = C_V;
            mW     = addM(wt, D_V);
            mCount = mCount + 16'd1;
        end else begin
            mV = vt;
            mW = wt;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " v"}, v_state, fromVal(mV));
        checkOutput({tag, " w"}, w_state, fromVal(mW));
`ifdef IZH_SPIKE_COUNT_EN
        checkOutput({tag, " count"}, 32'(spike_count), 32'(mCount));
`endif
    endtask

    // One start pulse; done must arrive on the 4th rising edge counting the one that samples start.
    task automatic applyStimulus(input logic [31:0] dv, input string tag);
        int lat;
        bit seen;
        bit fire;
        modelStep(toVal(dv), fire);
        @(negedge clk);
        start = 1'b1;
        dv_in = dv;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " early done"}, 32'(done), 32'd0);
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'd4);
        checkOutput({tag, " spike"}, 32'(spike), 32'(fire));
        checkState(tag);
        dv_in = $urandom;
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 32'({done, spike, busy}), 32'd0);
    endtask

    initial begin
        bit fire;
        logic [31:0] dv;
        logic [31:0] r;
        int doneCount;

        // T1: reset values
        doReset(2);
        checkOutput("t1 v", v_state, 32'h80410000);
        checkOutput("t1 w", w_state, 32'h800D0000);
        checkOutput("t1 flags", 32'({busy, done, spike}), 32'd0);

        // T2: sub-threshold step
        applyStimulus(32'h00020000, "t2");
        checkOutput("t2 v const", v_state, 32'h803F0000);
        checkOutput("t2 w const", w_state, 32'h800D0000);

        // T3: spiking step
        doReset(2);
        applyStimulus(32'h00640000, "t3");
        checkOutput("t3 v const", v_state, 32'h80410000);
        checkOutput("t3 w const", w_state, 32'h80050000);

        // T4: start held for 8 cycles
        doReset(2);
        @(negedge clk);
        start = 1'b1;
        dv_in = 32'h00020000;
        modelStep(toVal(dv_in), fire);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 7) start = 1'b0;
            checkOutput($sformatf("t4 done c%0d", i), 32'(done), 32'((i == 3) || (i == 8)));
            checkOutput($sformatf("t4 busy c%0d", i), 32'(busy), 32'(!((i == 4) || (i == 9))));
            if (i == 3) begin
                checkState("t4 first");
                modelStep(toVal(dv_in), fire);
            end
            if (i == 8) checkState("t4 second");
        end

        // Random steps against the model
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            if (r[0]) dv = $urandom;
            else dv = {r[1], 7'd0, 8'($urandom_range(0, 60)), 16'($urandom)};
            applyStimulus(dv, $sformatf("rnd%0d", n));
            if (n == 20) doReset(1);
        end

        // T5: reset while in INTEGRATE aborts the step
        @(negedge clk);
        start = 1'b1;
        dv_in = 32'h00640000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("t5 busy", 32'(busy), 32'd0);
        checkState("t5");
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || spike) doneCount++;
        end
        checkOutput("t5 no done", 32'(doneCount), 32'd0);

`ifdef IZH_SPIKE_COUNT_EN
        // T6: spike counter and wrap
        doReset(2);
        for (int i = 0; i < 3; i++) applyStimulus(32'h00640000, $sformatf("t6 s%0d", i));
        checkOutput("t6 count3", 32'(spike_count), 32'd3);
        doReset(2);
        @(negedge clk);
        force dut.r_spikeCount = 16'hFFFF;
        @(negedge clk);
        release dut.r_spikeCount;
        mCount = 16'hFFFF;
        applyStimulus(32'h00640000, "t6 wrap");
        checkOutput("t6 wrap zero", 32'(spike_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
